sid_bus_responder: RTL and testbench

//  FPGA-side responder for the 6581/8580 SID host bus: the chip end of the bus our SID driver masters.

---
 rtl/sid_bus_responder.sv | 155 +++++++++++++++
 tb/tb_sid_bus_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sid_bus_responder.sv
// SID host-bus responder: synchronises phi2/CS/RW/ADDR/DATA, captures writes into the register file and serves reads.
// Write strobe lands SYNC_STAGES+1 clocks after phi2 falls, and read drive follows phi2 by the same delay; the bus has no backpressure.
module sid_bus_responder #(
    parameter int          SYNC_STAGES  = 2,
    parameter int          NUM_WREGS    = 25,
    parameter logic [23:0] DECAY_CYCLES = 24'd2000000
) (
    input  logic                   C6_CLK_8MHZ,
    input  logic                   C6_RESET,
    input  logic                   SID_CLK,
    input  logic                   SID_CS,
    input  logic                   SID_RW,
    input  logic                   SID_RES,
    input  logic [4:0]             SID_ADDR,
    input  logic [7:0]             SID_DATA_IN,
    output logic [7:0]             SID_DATA_OUT,
    output logic                   SID_DATA_OE,
    input  logic [7:0]             POTX,
    input  logic [7:0]             POTY,
    input  logic [7:0]             OSC3,
    input  logic [7:0]             ENV3,
    output logic                   WR_STB,
    output logic [4:0]             WR_ADDR,
    output logic [7:0]             WR_DATA,
    output logic [8*NUM_WREGS-1:0] REG_FLAT
);

    typedef struct packed {
        logic       phi;
        logic       cs;
        logic       rw;
        logic       res;
        logic [4:0] addr;
        logic [7:0] data;
    } bus_t;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_DRIVE = 1'b1
    } rd_state_t;

    localparam logic [5:0] NUM_WREGS_W = 6'(NUM_WREGS);

    bus_t                         bus_in;
    bus_t [SYNC_STAGES-1:0]       sync_q;
    bus_t                         bus_s;
    logic                         phi_d;
    logic                         phi_fall;
    logic                         bus_rst;
    logic                         wr_fall;
    logic                         addr_ok;
    logic [NUM_WREGS-1:0][7:0]    regs;
    logic [7:0]                   bus_latch;
    logic [23:0]                  decay_cnt;
    logic [7:0]                   rd_mux;
    rd_state_t                    rd_state;

    assign bus_in = '{phi:  SID_CLK,
                      cs:   SID_CS,
                      rw:   SID_RW,
                      res:  SID_RES,
                      addr: SID_ADDR,
                      data: SID_DATA_IN};

    // All bus lines share one chain so every field of bus_s comes from the same sample instant.
    always_ff @(posedge C6_CLK_8MHZ) begin
        if (C6_RESET) begin
            sync_q <= '0;
            phi_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus_in};
            phi_d  <= bus_s.phi;
        end
    end

    assign bus_s    = sync_q[SYNC_STAGES-1];
    assign bus_rst  = C6_RESET | ~bus_s.res;
    assign phi_fall = phi_d & ~bus_s.phi;
    assign wr_fall  = phi_fall & ~bus_s.cs & ~bus_s.rw;
    assign addr_ok  = {1'b0, bus_s.addr} < NUM_WREGS_W;
    assign REG_FLAT = regs;

    // Register file, write strobe and the decaying bus latch.
    always_ff @(posedge C6_CLK_8MHZ) begin
        if (bus_rst) begin
            regs      <= '0;
            WR_STB    <= 1'b0;
            WR_ADDR   <= '0;
            WR_DATA   <= '0;
            bus_latch <= '0;
            decay_cnt <= '0;
        end else begin
            WR_STB <= 1'b0;
            if (wr_fall) begin
                bus_latch <= bus_s.data;
                decay_cnt <= '0;
                if (addr_ok) begin
                    for (int i = 0; i < NUM_WREGS; i++) begin
                        if (bus_s.addr == 5'(i)) regs[i] <= bus_s.data;
                    end
                    WR_STB  <= 1'b1;
                    WR_ADDR <= bus_s.addr;
                    WR_DATA <= bus_s.data;
                end
            end else if (decay_cnt == DECAY_CYCLES) begin
                bus_latch <= '0;
            end else begin
                decay_cnt <= decay_cnt + 24'd1;
            end
        end
    end

    always_comb begin
        rd_mux = bus_latch;
        case (bus_s.addr)
            5'h19:   rd_mux = POTX;
            5'h1A:   rd_mux = POTY;
            5'h1B:   rd_mux = OSC3;
            5'h1C:   rd_mux = ENV3;
            default: rd_mux = bus_latch;
        endcase
    end

    // Read drive: a falling phi2 always ends the drive phase, even if CS/RW still request a read.
    always_ff @(posedge C6_CLK_8MHZ) begin
        if (bus_rst) begin
            rd_state     <= RD_IDLE;
            SID_DATA_OE  <= 1'b0;
            SID_DATA_OUT <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (bus_s.phi && !bus_s.cs && bus_s.rw) begin
                        rd_state     <= RD_DRIVE;
                        SID_DATA_OE  <= 1'b1;
                        SID_DATA_OUT <= rd_mux;
                    end
                end
                RD_DRIVE: begin
                    if (phi_fall || bus_s.cs || !bus_s.rw) begin
                        rd_state    <= RD_IDLE;
                        SID_DATA_OE <= 1'b0;
                    end else begin
                        SID_DATA_OUT <= rd_mux;
                    end
                end
                default: begin
                    rd_state    <= RD_IDLE;
                    SID_DATA_OE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sid_bus_responder.sv
// Directed bench for sid_bus_responder: bus writes/reads at a 16-clock phi2 period, decay, and reset corner cases.
module tb_sid_bus_responder;

    localparam int SYNC = 2;
    localparam int NREG = 25;

    logic            C6_CLK_8MHZ = 1'b0;
    logic            C6_RESET    = 1'b0;
    logic            SID_CLK     = 1'b0;
    logic            SID_CS      = 1'b1;
    logic            SID_RW      = 1'b1;
    logic            SID_RES     = 1'b1;
    logic [4:0]      SID_ADDR    = '0;
    logic [7:0]      SID_DATA_IN = '0;
    logic [7:0]      SID_DATA_OUT;
    logic            SID_DATA_OE;
    logic [7:0]      POTX = 8'h12;
    logic [7:0]      POTY = 8'h34;
    logic [7:0]      OSC3 = 8'hA5;
    logic [7:0]      ENV3 = 8'hC3;
    logic            WR_STB;
    logic [4:0]      WR_ADDR;
    logic [7:0]      WR_DATA;
    logic [8*NREG-1:0] REG_FLAT;

    int n_checks = 0;
    int n_errors = 0;

    logic [8*NREG-1:0] exp_flat = '0;

    int         stb_edge, stb_cnt, drop_lat;
    logic [4:0] wa;
    logic [7:0] wd, rd;
    bit         oe_seen;

    sid_bus_responder #(
        .SYNC_STAGES (SYNC),
        .NUM_WREGS   (NREG),
        .DECAY_CYCLES(24'd100)
    ) dut (
        .C6_CLK_8MHZ (C6_CLK_8MHZ),
        .C6_RESET    (C6_RESET),
        .SID_CLK     (SID_CLK),
        .SID_CS      (SID_CS),
        .SID_RW      (SID_RW),
        .SID_RES     (SID_RES),
        .SID_ADDR    (SID_ADDR),
        .SID_DATA_IN (SID_DATA_IN),
        .SID_DATA_OUT(SID_DATA_OUT),
        .SID_DATA_OE (SID_DATA_OE),
        .POTX        (POTX),
        .POTY        (POTY),
        .OSC3        (OSC3),
        .ENV3        (ENV3),
        .WR_STB      (WR_STB),
        .WR_ADDR     (WR_ADDR),
        .WR_DATA     (WR_DATA),
        .REG_FLAT    (REG_FLAT)
    );

    always #5 C6_CLK_8MHZ = ~C6_CLK_8MHZ;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One phi2 cycle (8 low, 8 high) writing a to d; CS level and an optional reset are applied around the fall.
    task automatic bus_write(input logic [4:0] a, input logic [7:0] d, input bit cs_high_at_fall,
                             input bit rst_at_fall, output int se, output int sc,
                             output logic [4:0] oa, output logic [7:0] od);
        @(negedge C6_CLK_8MHZ);
        SID_CS = 1'b0; SID_RW = 1'b0; SID_ADDR = a; SID_DATA_IN = d;
        repeat (8) @(negedge C6_CLK_8MHZ);
        SID_CLK = 1'b1;
        repeat (8) @(negedge C6_CLK_8MHZ);
        SID_CLK = 1'b0;
        SID_CS  = cs_high_at_fall;
        se = 0; sc = 0; oa = '0; od = '0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge C6_CLK_8MHZ); #1;
            if (WR_STB) begin
                if (sc == 0) begin
                    se = k; oa = WR_ADDR; od = WR_DATA;
                end
                sc++;
            end
            if (rst_at_fall) C6_RESET = (k == SYNC);
        end
        SID_CS = 1'b1; SID_RW = 1'b1;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [7:0] data, output bit seen, output int drop);
        @(negedge C6_CLK_8MHZ);
        SID_CS = 1'b0; SID_RW = 1'b1; SID_ADDR = a;
        repeat (8) @(negedge C6_CLK_8MHZ);
        SID_CLK = 1'b1;
        seen = 1'b0; data = '0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge C6_CLK_8MHZ); #1;
            if (SID_DATA_OE) begin
                seen = 1'b1; data = SID_DATA_OUT;
            end
        end
        @(negedge C6_CLK_8MHZ);
        SID_CLK = 1'b0;
        drop = 99;
        for (int k = 1; k <= 10; k++) begin
            @(posedge C6_CLK_8MHZ); #1;
            if (!SID_DATA_OE && drop == 99) drop = k;
        end
        SID_CS = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset
        C6_RESET = 1'b1;
        repeat (2) @(posedge C6_CLK_8MHZ);
        @(negedge C6_CLK_8MHZ);
        check("rst_regs",  REG_FLAT,     '0);
        check("rst_oe",    SID_DATA_OE,  0);
        check("rst_stb",   WR_STB,       0);
        check("rst_dout",  SID_DATA_OUT, 0);
        C6_RESET = 1'b0;
        repeat (4) @(negedge C6_CLK_8MHZ);

        // Write to the last register
        bus_write(5'h18, 8'h0F, 1'b0, 1'b0, stb_edge, stb_cnt, wa, wd);
        exp_flat[8*24 +: 8] = 8'h0F;
        check("w18_stb_edge", stb_edge, SYNC + 1);
        check("w18_stb_cnt",  stb_cnt,  1);
        check("w18_addr",     wa,       5'h18);
        check("w18_data",     wd,       8'h0F);
        check("w18_regs",     REG_FLAT, exp_flat);

        // Read-only sources
        bus_read(5'h1B, rd, oe_seen, drop_lat);
        check("r1b_oe",   oe_seen, 1);
        check("r1b_data", rd,      8'hA5);
        check("r1b_drop", (drop_lat >= 1) && (drop_lat <= SYNC + 1), 1);
        bus_read(5'h19, rd, oe_seen, drop_lat);
        check("r19_data", rd, 8'h12);
        bus_read(5'h1A, rd, oe_seen, drop_lat);
        check("r1a_data", rd, 8'h34);
        bus_read(5'h1C, rd, oe_seen, drop_lat);
        check("r1c_data", rd, 8'hC3);

        // Write then read back through the bus latch, then let it decay
        bus_write(5'h00, 8'h3C, 1'b0, 1'b0, stb_edge, stb_cnt, wa, wd);
        exp_flat[7:0] = 8'h3C;
        check("w00_stb_cnt", stb_cnt,  1);
        check("w00_addr",    wa,       5'h00);
        check("w00_regs",    REG_FLAT, exp_flat);
        bus_read(5'h00, rd, oe_seen, drop_lat);
        check("r00_latch", rd, 8'h3C);
        repeat (100) @(negedge C6_CLK_8MHZ);
        bus_read(5'h05, rd, oe_seen, drop_lat);
        check("r05_decayed", rd, 8'h00);

        // Out-of-range write only loads the latch
        bus_write(5'h1D, 8'h77, 1'b0, 1'b0, stb_edge, stb_cnt, wa, wd);
        check("w1d_no_stb", stb_cnt,  0);
        check("w1d_regs",   REG_FLAT, exp_flat);
        bus_read(5'h02, rd, oe_seen, drop_lat);
        check("r02_latch", rd, 8'h77);

        // CS deasserted at the fall
        bus_write(5'h03, 8'h55, 1'b1, 1'b0, stb_edge, stb_cnt, wa, wd);
        check("cs_no_stb", stb_cnt,  0);
        check("cs_regs",   REG_FLAT, exp_flat);

        // Reset on the fall cycle drops the write and clears everything
        bus_write(5'h07, 8'h99, 1'b0, 1'b1, stb_edge, stb_cnt, wa, wd);
        exp_flat = '0;
        check("rstfall_no_stb", stb_cnt,  0);
        check("rstfall_regs",   REG_FLAT, exp_flat);

        // Bus reset via SID_RES
        bus_write(5'h01, 8'h44, 1'b0, 1'b0, stb_edge, stb_cnt, wa, wd);
        exp_flat[15:8] = 8'h44;
        check("w01_regs", REG_FLAT, exp_flat);
        bus_read(5'h1B, rd, oe_seen, drop_lat);
        check("r1b_again", rd, 8'hA5);
        @(negedge C6_CLK_8MHZ);
        SID_RES = 1'b0;
        repeat (SYNC + 3) @(negedge C6_CLK_8MHZ);
        check("sidres_regs", REG_FLAT,     '0);
        check("sidres_oe",   SID_DATA_OE,  0);
        check("sidres_stb",  WR_STB,       0);
        check("sidres_dout", SID_DATA_OUT, 0);
        SID_RES = 1'b1;
        repeat (SYNC + 3) @(negedge C6_CLK_8MHZ);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
